// File: rtl/axi4_lite_register_slice_if.sv
// axi4_if: AXI4 bus bundle shared by both sides of the register slice.
//   A  - address width
//   N  - data bus width in bytes
//   I  - ID width
// Modports:
//   master - issues AW/W/AR, receives B/R
//   slave  - receives AW/W/AR, returns B/R
interface axi4_if #(
  parameter int A = 32,
  parameter int N = 8,
  parameter int I = 4
);
  // write address
  logic [I-1:0]   awid;
  logic [A-1:0]   awaddr;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic           awlock;
  logic [3:0]     awcache;
  logic [2:0]     awprot;
  logic [3:0]     awqos;
  logic [3:0]     awregion;
  logic           awvalid;
  logic           awready;
  // write data
  logic [I-1:0]   wid;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wlast;
  logic           wvalid;
  logic           wready;
  // write response
  logic [I-1:0]   bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  // read address
  logic [I-1:0]   arid;
  logic [A-1:0]   araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arlock;
  logic [3:0]     arcache;
  logic [2:0]     arprot;
  logic [3:0]     arqos;
  logic [3:0]     arregion;
  logic           arvalid;
  logic           arready;
  // read data
  logic [I-1:0]   rid;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_lite_register_slice.sv
// axi4_lite_register_slice: AXI4-Lite pipeline stage. Each of the five
// channels is independently a pass-through (0), a full skid buffer (1) or a
// light single register (2). AXI4-only fields toward the downstream slave are
// tied to their AXI4-Lite constants.
//
// Handshake: on every channel the source raises valid with a payload and holds
// both unchanged until it samples ready high; a beat transfers on each clk
// edge where valid && ready. Ready may depend on nothing from valid.
//
// Ports:
//   clk    - single clock for all channels
//   reset  - asynchronous, active-high
//   axi4_s - slave side (upstream master): receives AW/W/AR, returns B/R
//   axi4_m - master side (downstream slave): issues AW/W/AR, receives B/R

// axi4_lite_channel_slice: one channel of the slice.
//   up_*  - source side (presents valid/payload, receives ready)
//   dn_*  - sink side (receives valid/payload, presents ready)
module axi4_lite_channel_slice #(
  parameter int W    = 8,
  parameter int MODE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  if (MODE == 1) begin : g_full
    logic         main_valid, skid_valid, ready_q;
    logic [W-1:0] main_data, skid_data;
    logic         main_valid_nxt, skid_valid_nxt;
    logic [W-1:0] main_data_nxt, skid_data_nxt;
    logic         up_fire, main_free;

    always_comb begin
      up_fire        = up_valid && ready_q;
      // main can take a beat when it is empty or emptying on this edge
      main_free      = !main_valid || dn_ready;
      main_valid_nxt = main_valid;
      main_data_nxt  = main_data;
      skid_valid_nxt = skid_valid;
      skid_data_nxt  = skid_data;
      if (main_free) begin
        if (skid_valid) begin
          // ready_q is low while skid holds a beat, so no upstream beat here
          main_valid_nxt = 1'b1;
          main_data_nxt  = skid_data;
          skid_valid_nxt = 1'b0;
        end else if (up_fire) begin
          main_valid_nxt = 1'b1;
          main_data_nxt  = up_data;
        end else begin
          main_valid_nxt = 1'b0;
        end
      end else if (up_fire) begin
        skid_valid_nxt = 1'b1;
        skid_data_nxt  = up_data;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        main_valid <= 1'b0;
        main_data  <= '0;
        skid_valid <= 1'b0;
        skid_data  <= '0;
        ready_q    <= 1'b0;
      end else begin
        main_valid <= main_valid_nxt;
        main_data  <= main_data_nxt;
        skid_valid <= skid_valid_nxt;
        skid_data  <= skid_data_nxt;
        // registered so dn_ready never reaches up_ready combinationally
        ready_q    <= !skid_valid_nxt;
      end
    end

    assign up_ready = ready_q;
    assign dn_valid = main_valid;
    assign dn_data  = main_data;

  end else if (MODE == 2) begin : g_light
    logic         main_valid;
    logic [W-1:0] main_data;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        main_valid <= 1'b0;
        main_data  <= '0;
      end else if (main_valid) begin
        if (dn_ready) main_valid <= 1'b0;
      end else if (up_valid) begin
        main_valid <= 1'b1;
        main_data  <= up_data;
      end
    end

    assign up_ready = !main_valid;
    assign dn_valid = main_valid;
    assign dn_data  = main_data;

  end else begin : g_pass
    // mode 0 (and any unsupported encoding) is a plain wire-through
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign up_ready = dn_ready;
    assign dn_valid = up_valid;
    assign dn_data  = up_data;
  end

endmodule

module axi4_lite_register_slice #(
  parameter int A       = 32,
  parameter int N       = 8,
  parameter int AW_MODE = 1,
  parameter int W_MODE  = 1,
  parameter int B_MODE  = 1,
  parameter int AR_MODE = 1,
  parameter int R_MODE  = 1
) (
  input  logic   clk,
  input  logic   reset,
  axi4_if.slave  axi4_s,
  axi4_if.master axi4_m
);

  localparam int AXW = A + 3;        // {prot, addr}
  localparam int WW  = 8 * N + N;    // {strb, data}
  localparam int BW  = 2;            // resp
  localparam int RW  = 8 * N + 2;    // {resp, data}

  logic [AXW-1:0] aw_dn, ar_dn;
  logic [WW-1:0]  w_dn;
  logic [BW-1:0]  b_dn;
  logic [RW-1:0]  r_dn;

  axi4_lite_channel_slice #(.W(AXW), .MODE(AW_MODE)) u_aw (
    .clk      (clk),
    .reset    (reset),
    .up_valid (axi4_s.awvalid),
    .up_ready (axi4_s.awready),
    .up_data  ({axi4_s.awprot, axi4_s.awaddr}),
    .dn_valid (axi4_m.awvalid),
    .dn_ready (axi4_m.awready),
    .dn_data  (aw_dn)
  );

  axi4_lite_channel_slice #(.W(WW), .MODE(W_MODE)) u_w (
    .clk      (clk),
    .reset    (reset),
    .up_valid (axi4_s.wvalid),
    .up_ready (axi4_s.wready),
    .up_data  ({axi4_s.wstrb, axi4_s.wdata}),
    .dn_valid (axi4_m.wvalid),
    .dn_ready (axi4_m.wready),
    .dn_data  (w_dn)
  );

  // B and R flow from the downstream slave back to the upstream master
  axi4_lite_channel_slice #(.W(BW), .MODE(B_MODE)) u_b (
    .clk      (clk),
    .reset    (reset),
    .up_valid (axi4_m.bvalid),
    .up_ready (axi4_m.bready),
    .up_data  (axi4_m.bresp),
    .dn_valid (axi4_s.bvalid),
    .dn_ready (axi4_s.bready),
    .dn_data  (b_dn)
  );

  axi4_lite_channel_slice #(.W(AXW), .MODE(AR_MODE)) u_ar (
    .clk      (clk),
    .reset    (reset),
    .up_valid (axi4_s.arvalid),
    .up_ready (axi4_s.arready),
    .up_data  ({axi4_s.arprot, axi4_s.araddr}),
    .dn_valid (axi4_m.arvalid),
    .dn_ready (axi4_m.arready),
    .dn_data  (ar_dn)
  );

  axi4_lite_channel_slice #(.W(RW), .MODE(R_MODE)) u_r (
    .clk      (clk),
    .reset    (reset),
    .up_valid (axi4_m.rvalid),
    .up_ready (axi4_m.rready),
    .up_data  ({axi4_m.rresp, axi4_m.rdata}),
    .dn_valid (axi4_s.rvalid),
    .dn_ready (axi4_s.rready),
    .dn_data  (r_dn)
  );

  assign axi4_m.awprot = aw_dn[A +: 3];
  assign axi4_m.awaddr = aw_dn[A-1:0];
  assign axi4_m.wstrb  = w_dn[8*N +: N];
  assign axi4_m.wdata  = w_dn[8*N-1:0];
  assign axi4_s.bresp  = b_dn;
  assign axi4_m.arprot = ar_dn[A +: 3];
  assign axi4_m.araddr = ar_dn[A-1:0];
  assign axi4_s.rresp  = r_dn[8*N +: 2];
  assign axi4_s.rdata  = r_dn[8*N-1:0];

  // AXI4-Lite: single-beat INCR bursts of full bus width, no IDs or QoS
  assign axi4_m.awid     = '0;
  assign axi4_m.awlen    = 8'd0;
  assign axi4_m.awsize   = 3'($clog2(N));
  assign axi4_m.awburst  = 2'b01;
  assign axi4_m.awlock   = 1'b0;
  assign axi4_m.awcache  = 4'd0;
  assign axi4_m.awqos    = 4'd0;
  assign axi4_m.awregion = 4'd0;
  assign axi4_m.wid      = '0;
  assign axi4_m.wlast    = 1'b1;
  assign axi4_m.arid     = '0;
  assign axi4_m.arlen    = 8'd0;
  assign axi4_m.arsize   = 3'($clog2(N));
  assign axi4_m.arburst  = 2'b01;
  assign axi4_m.arlock   = 1'b0;
  assign axi4_m.arcache  = 4'd0;
  assign axi4_m.arqos    = 4'd0;
  assign axi4_m.arregion = 4'd0;
  assign axi4_s.bid      = '0;
  assign axi4_s.rid      = '0;
  assign axi4_s.rlast    = 1'b1;

  // AXI4-only fields arriving on either side carry no meaning here
  logic unused_axi4_fields;
  assign unused_axi4_fields = ^{axi4_s.awid, axi4_s.awlen, axi4_s.awsize, axi4_s.awburst,
                                axi4_s.awlock, axi4_s.awcache, axi4_s.awqos, axi4_s.awregion,
                                axi4_s.wid, axi4_s.wlast,
                                axi4_s.arid, axi4_s.arlen, axi4_s.arsize, axi4_s.arburst,
                                axi4_s.arlock, axi4_s.arcache, axi4_s.arqos, axi4_s.arregion,
                                axi4_m.bid, axi4_m.rid, axi4_m.rlast};

endmodule

// File: tb/tb_axi4_lite_register_slice.sv
// Bench for axi4_lite_register_slice. Two instances: u_full (all channels
// full) and u_mix (AW pass-through, W full, B light, AR full, R full).
// A channel model tracks the beats each channel holds (queue of accepted
// payloads) and derives valid/ready/payload from the occupancy rules.
module tb_axi4_lite_register_slice;

  localparam int CW = 80;

  logic clk;
  logic reset;

  axi4_if #(.A(32), .N(8)) s0 ();
  axi4_if #(.A(32), .N(8)) m0 ();
  axi4_if #(.A(32), .N(8)) s1 ();
  axi4_if #(.A(32), .N(8)) m1 ();

  axi4_lite_register_slice #(.A(32), .N(8), .AW_MODE(1), .W_MODE(1), .B_MODE(1),
                             .AR_MODE(1), .R_MODE(1)) u_full (
    .clk    (clk),
    .reset  (reset),
    .axi4_s (s0),
    .axi4_m (m0)
  );

  axi4_lite_register_slice #(.A(32), .N(8), .AW_MODE(0), .W_MODE(1), .B_MODE(2),
                             .AR_MODE(1), .R_MODE(1)) u_mix (
    .clk    (clk),
    .reset  (reset),
    .axi4_s (s1),
    .axi4_m (m1)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [CW-1:0] act,
                              input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R (u_full); +5 for u_mix
  function automatic int mode_of(input int c);
    int m;
    m = 1;
    if (c == 5) m = 0;
    if (c == 7) m = 2;
    return m;
  endfunction

  logic [9:0]    up_v, up_r, dn_v, dn_r;
  logic [CW-1:0] up_d [10];
  logic [CW-1:0] dn_d [10];

  assign up_v[0] = s0.awvalid; assign up_r[0] = s0.awready; assign up_d[0] = CW'({s0.awprot, s0.awaddr});
  assign dn_v[0] = m0.awvalid; assign dn_r[0] = m0.awready; assign dn_d[0] = CW'({m0.awprot, m0.awaddr});
  assign up_v[1] = s0.wvalid;  assign up_r[1] = s0.wready;  assign up_d[1] = CW'({s0.wstrb, s0.wdata});
  assign dn_v[1] = m0.wvalid;  assign dn_r[1] = m0.wready;  assign dn_d[1] = CW'({m0.wstrb, m0.wdata});
  assign up_v[2] = m0.bvalid;  assign up_r[2] = m0.bready;  assign up_d[2] = CW'(m0.bresp);
  assign dn_v[2] = s0.bvalid;  assign dn_r[2] = s0.bready;  assign dn_d[2] = CW'(s0.bresp);
  assign up_v[3] = s0.arvalid; assign up_r[3] = s0.arready; assign up_d[3] = CW'({s0.arprot, s0.araddr});
  assign dn_v[3] = m0.arvalid; assign dn_r[3] = m0.arready; assign dn_d[3] = CW'({m0.arprot, m0.araddr});
  assign up_v[4] = m0.rvalid;  assign up_r[4] = m0.rready;  assign up_d[4] = CW'({m0.rresp, m0.rdata});
  assign dn_v[4] = s0.rvalid;  assign dn_r[4] = s0.rready;  assign dn_d[4] = CW'({s0.rresp, s0.rdata});

  assign up_v[5] = s1.awvalid; assign up_r[5] = s1.awready; assign up_d[5] = CW'({s1.awprot, s1.awaddr});
  assign dn_v[5] = m1.awvalid; assign dn_r[5] = m1.awready; assign dn_d[5] = CW'({m1.awprot, m1.awaddr});
  assign up_v[6] = s1.wvalid;  assign up_r[6] = s1.wready;  assign up_d[6] = CW'({s1.wstrb, s1.wdata});
  assign dn_v[6] = m1.wvalid;  assign dn_r[6] = m1.wready;  assign dn_d[6] = CW'({m1.wstrb, m1.wdata});
  assign up_v[7] = m1.bvalid;  assign up_r[7] = m1.bready;  assign up_d[7] = CW'(m1.bresp);
  assign dn_v[7] = s1.bvalid;  assign dn_r[7] = s1.bready;  assign dn_d[7] = CW'(s1.bresp);
  assign up_v[8] = s1.arvalid; assign up_r[8] = s1.arready; assign up_d[8] = CW'({s1.arprot, s1.araddr});
  assign dn_v[8] = m1.arvalid; assign dn_r[8] = m1.arready; assign dn_d[8] = CW'({m1.arprot, m1.araddr});
  assign up_v[9] = m1.rvalid;  assign up_r[9] = m1.rready;  assign up_d[9] = CW'({m1.rresp, m1.rdata});
  assign dn_v[9] = s1.rvalid;  assign dn_r[9] = s1.rready;  assign dn_d[9] = CW'({s1.rresp, s1.rdata});

  // constant fields: {aw*, wid, wlast, ar*} on master side, {bid, rid, rlast} on slave side
  localparam logic [29:0] AX_EXP  = {4'd0, 8'd0, 3'd3, 2'd1, 1'b0, 4'd0, 4'd0, 4'd0};
  localparam logic [73:0] CST_EXP = {AX_EXP, 4'd0, 1'b1, AX_EXP, 4'd0, 4'd0, 1'b1};
  logic [73:0] cst0, cst1;
  assign cst0 = {m0.awid, m0.awlen, m0.awsize, m0.awburst, m0.awlock, m0.awcache, m0.awqos,
                 m0.awregion, m0.wid, m0.wlast, m0.arid, m0.arlen, m0.arsize, m0.arburst,
                 m0.arlock, m0.arcache, m0.arqos, m0.arregion, s0.bid, s0.rid, s0.rlast};
  assign cst1 = {m1.awid, m1.awlen, m1.awsize, m1.awburst, m1.awlock, m1.awcache, m1.awqos,
                 m1.awregion, m1.wid, m1.wlast, m1.arid, m1.arlen, m1.arsize, m1.arburst,
                 m1.arlock, m1.arcache, m1.arqos, m1.arregion, s1.bid, s1.rid, s1.rlast};

  // ---------------- scoreboard / model ----------------
  logic [CW-1:0] exp_q [10][$];
  int  dlv [10];
  bit  armed = 1'b0;   // a registered ready may be high only after one clean edge

  initial for (int c = 0; c < 10; c++) dlv[c] = 0;

  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < 10; c++) exp_q[c].delete();
      armed = 1'b0;
    end
    for (int c = 0; c < 10; c++) begin
      int   m;
      int   occ;
      logic ev, er;
      m   = mode_of(c);
      occ = exp_q[c].size();
      if (m == 0) begin
        chk($sformatf("ch%0d_pass_valid", c), CW'(dn_v[c]), CW'(up_v[c]));
        chk($sformatf("ch%0d_pass_ready", c), CW'(up_r[c]), CW'(dn_r[c]));
        if (up_v[c]) chk($sformatf("ch%0d_pass_data", c), dn_d[c], up_d[c]);
      end else begin
        ev = (occ > 0);
        er = (m == 1) ? (armed && occ < 2) : (occ == 0);
        chk($sformatf("ch%0d_valid", c), CW'(dn_v[c]), CW'(ev));
        chk($sformatf("ch%0d_ready", c), CW'(up_r[c]), CW'(er));
        if (dn_v[c] && occ > 0) chk($sformatf("ch%0d_data", c), dn_d[c], exp_q[c][0]);
      end
      if (!reset) begin
        if (m != 0) begin
          if (dn_v[c] && dn_r[c] && exp_q[c].size() > 0) void'(exp_q[c].pop_front());
          if (up_v[c] && up_r[c]) exp_q[c].push_back(up_d[c]);
        end
        if (dn_v[c] && dn_r[c]) dlv[c]++;
      end
    end
    chk("consts_full", CW'(cst0), CW'(CST_EXP));
    chk("consts_mix", CW'(cst1), CW'(CST_EXP));
    armed = !reset;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    s0.awid = '0; s0.awaddr = '0; s0.awlen = '0; s0.awsize = '0; s0.awburst = '0;
    s0.awlock = 1'b0; s0.awcache = '0; s0.awprot = '0; s0.awqos = '0; s0.awregion = '0;
    s0.awvalid = 1'b0; s0.wid = '0; s0.wdata = '0; s0.wstrb = '0; s0.wlast = 1'b0;
    s0.wvalid = 1'b0; s0.bready = 1'b0; s0.arid = '0; s0.araddr = '0; s0.arlen = '0;
    s0.arsize = '0; s0.arburst = '0; s0.arlock = 1'b0; s0.arcache = '0; s0.arprot = '0;
    s0.arqos = '0; s0.arregion = '0; s0.arvalid = 1'b0; s0.rready = 1'b0;
    s1.awid = '0; s1.awaddr = '0; s1.awlen = '0; s1.awsize = '0; s1.awburst = '0;
    s1.awlock = 1'b0; s1.awcache = '0; s1.awprot = '0; s1.awqos = '0; s1.awregion = '0;
    s1.awvalid = 1'b0; s1.wid = '0; s1.wdata = '0; s1.wstrb = '0; s1.wlast = 1'b0;
    s1.wvalid = 1'b0; s1.bready = 1'b0; s1.arid = '0; s1.araddr = '0; s1.arlen = '0;
    s1.arsize = '0; s1.arburst = '0; s1.arlock = 1'b0; s1.arcache = '0; s1.arprot = '0;
    s1.arqos = '0; s1.arregion = '0; s1.arvalid = 1'b0; s1.rready = 1'b0;
    m0.awready = 1'b0; m0.wready = 1'b0; m0.bid = '0; m0.bresp = '0; m0.bvalid = 1'b0;
    m0.arready = 1'b0; m0.rid = '0; m0.rdata = '0; m0.rresp = '0; m0.rlast = 1'b0;
    m0.rvalid = 1'b0;
    m1.awready = 1'b0; m1.wready = 1'b0; m1.bid = '0; m1.bresp = '0; m1.bvalid = 1'b0;
    m1.arready = 1'b0; m1.rid = '0; m1.rdata = '0; m1.rresp = '0; m1.rlast = 1'b0;
    m1.rvalid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  int up_fires, dn_fires, dlv_w0;

  initial begin
    reset = 1'b0;
    idle_all();
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", CW'(s0.awready), CW'(0));
    chk("rst_m_awvalid", CW'(m0.awvalid), CW'(0));
    reset = 1'b0;
    chk("rel_awready_before_edge", CW'(s0.awready), CW'(0));
    tick();
    chk("rel_awready_after_edge", CW'(s0.awready), CW'(1));

    // AW + W through the full slice
    s0.awaddr = 32'h100; s0.awprot = 3'd3; s0.awvalid = 1'b1;
    s0.wdata = 64'hDEAD_BEEF_0000_0001; s0.wstrb = 8'hFF; s0.wvalid = 1'b1;
    chk("t1_no_zero_latency", CW'(m0.awvalid), CW'(0));
    tick();
    s0.awvalid = 1'b0; s0.wvalid = 1'b0;
    chk("t1_awvalid", CW'(m0.awvalid), CW'(1));
    chk("t1_awaddr", CW'(m0.awaddr), CW'(32'h100));
    chk("t1_awprot", CW'(m0.awprot), CW'(3));
    chk("t1_wvalid", CW'(m0.wvalid), CW'(1));
    chk("t1_wdata", CW'(m0.wdata), CW'(64'hDEAD_BEEF_0000_0001));
    chk("t1_wstrb", CW'(m0.wstrb), CW'(8'hFF));
    chk("t1_awlen", CW'(m0.awlen), CW'(0));
    chk("t1_awsize", CW'(m0.awsize), CW'(3));
    chk("t1_awburst", CW'(m0.awburst), CW'(1));
    chk("t1_wlast", CW'(m0.wlast), CW'(1));
    m0.awready = 1'b1; m0.wready = 1'b1;
    tick();
    chk("t1_drained", CW'(m0.awvalid), CW'(0));

    // AR stream, downstream always ready
    m0.arready = 1'b1;
    chk("t2_idle", CW'(m0.arvalid), CW'(0));
    for (int i = 0; i < 16; i++) begin
      s0.araddr = 32'(i); s0.arvalid = 1'b1;
      tick();
      chk($sformatf("t2_arvalid_%0d", i), CW'(m0.arvalid), CW'(1));
      chk($sformatf("t2_araddr_%0d", i), CW'(m0.araddr), CW'(i));
    end
    s0.arvalid = 1'b0;
    tick();
    chk("t2_done", CW'(m0.arvalid), CW'(0));

    // R stalled, three beats offered
    s0.rready = 1'b0;
    m0.rvalid = 1'b1; m0.rresp = 2'd2; m0.rdata = 64'd1;
    tick();
    m0.rdata = 64'd2;
    chk("t3_ready_beat2", CW'(m0.rready), CW'(1));
    tick();
    m0.rdata = 64'd3;
    chk("t3_ready_beat3", CW'(m0.rready), CW'(0));
    tick();
    chk("t3_still_stalled", CW'(m0.rready), CW'(0));
    chk("t3_head", CW'(s0.rdata), CW'(1));
    s0.rready = 1'b1;
    tick();
    chk("t3_ready_back", CW'(m0.rready), CW'(1));
    chk("t3_second", CW'(s0.rdata), CW'(2));
    tick();
    m0.rvalid = 1'b0;
    chk("t3_third", CW'(s0.rdata), CW'(3));
    chk("t3_rlast", CW'(s0.rlast), CW'(1));
    chk("t3_rresp", CW'(s0.rresp), CW'(2));
    tick();
    chk("t3_empty", CW'(s0.rvalid), CW'(0));
    s0.rready = 1'b0;

    // light B: continuous traffic, one beat every two cycles
    m1.bvalid = 1'b1; m1.bresp = 2'd2; s1.bready = 1'b1;
    up_fires = 0; dn_fires = 0;
    for (int i = 0; i < 12; i++) begin
      if (m1.bvalid && m1.bready) up_fires++;
      if (s1.bvalid && s1.bready) dn_fires++;
      tick();
    end
    chk("t4_accepted", CW'(up_fires), CW'(6));
    chk("t4_delivered", CW'(dn_fires), CW'(6));
    m1.bvalid = 1'b0;
    tick(); tick();
    s1.bready = 1'b0;

    // AW pass-through: combinational, zero latency
    s1.awaddr = 32'h40; s1.awprot = 3'd5; s1.awvalid = 1'b1; m1.awready = 1'b0;
    #1;
    chk("t5_aw_valid_comb", CW'(m1.awvalid), CW'(1));
    chk("t5_aw_addr_comb", CW'(m1.awaddr), CW'(32'h40));
    chk("t5_aw_ready_low", CW'(s1.awready), CW'(0));
    m1.awready = 1'b1;
    #1;
    chk("t5_aw_ready_comb", CW'(s1.awready), CW'(1));
    tick();
    s1.awvalid = 1'b0; m1.awready = 1'b0;

    // W full with an irregular downstream ready pattern
    dlv_w0 = dlv[6];
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          s1.wvalid = 1'b1; s1.wdata = 64'h1000 + 64'(k); s1.wstrb = 8'(1 << k);
          for (int g = 0; g < 20; g++) begin
            logic f;
            f = s1.wready;
            tick();
            if (f) break;
          end
        end
        s1.wvalid = 1'b0;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          m1.wready = (i % 3 != 1) || (i >= 24);
          tick();
        end
      end
    join
    chk("t5_w_delivered", CW'(dlv[6] - dlv_w0), CW'(5));
    chk("t5_w_queue_empty", CW'(exp_q[6].size()), CW'(0));
    m1.wready = 1'b0;

    // reset while the full slice holds two AW and two W beats
    m0.awready = 1'b0; m0.wready = 1'b0;
    s0.awvalid = 1'b1; s0.awaddr = 32'h200; s0.awprot = 3'd1;
    s0.wvalid = 1'b1; s0.wdata = 64'hA1; s0.wstrb = 8'h01;
    tick();
    s0.awaddr = 32'h204; s0.wdata = 64'hA2;
    tick();
    s0.awvalid = 1'b0; s0.wvalid = 1'b0;
    chk("t6_full_awready", CW'(s0.awready), CW'(0));
    chk("t6_held_awaddr", CW'(m0.awaddr), CW'(32'h200));
    #2 reset = 1'b1;
    #1;
    chk("t6_awvalid_drop", CW'(m0.awvalid), CW'(0));
    chk("t6_wvalid_drop", CW'(m0.wvalid), CW'(0));
    chk("t6_awready_rst", CW'(s0.awready), CW'(0));
    chk("t6_awaddr_clr", CW'(m0.awaddr), CW'(0));
    tick();
    tick();
    reset = 1'b0;
    chk("t6_awready_pre", CW'(s0.awready), CW'(0));
    tick();
    chk("t6_awready_post", CW'(s0.awready), CW'(1));
    m0.awready = 1'b1; m0.wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_no_stale_aw_%0d", i), CW'(m0.awvalid), CW'(0));
      chk($sformatf("t6_no_stale_w_%0d", i), CW'(m0.wvalid), CW'(0));
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_register_slice.md
Name: axi4_lite_register_slice

Overview:
- Parametrised AXI4-Lite pipeline stage between a slave-side axi4_if (axi4_s, driven by the upstream master) and a master-side axi4_if (axi4_m, toward downstream slave).
- Each of the five channels (AW, W, B, AR, R) is independently configurable as pass-through, full skid buffer or light single register.
- Breaks timing paths on long interconnect routes.
- Drives every AXI4-only field on axi4_m to its AXI4-Lite legal constant.

Parameters:
- A, 32, address width; must match axi4_if A.
- N, 8, data bus width in bytes; must match axi4_if N; legal values 1,2,4,8,16.
- AW_MODE, 1, AW channel mode: 0 = pass-through, 1 = full, 2 = light.
- W_MODE, 1, W channel mode, same encoding.
- B_MODE, 1, B channel mode, same encoding.
- AR_MODE, 1, AR channel mode, same encoding.
- R_MODE, 1, R channel mode, same encoding.

Ports:
- clk  input  1  single clock for all channels.
- reset  input  1  asynchronous, active-high reset.
- axi4_s  axi4_if  n/a  slave side; module receives AW/W/AR, returns B/R.
- axi4_m  axi4_if  n/a  master side; module issues AW/W/AR, receives B/R.

Behaviour:
- Payload per channel:
  - AW/AR: addr[A-1:0] and prot[2:0].
  - W: data[8N-1:0] and strb[N-1:0].
  - B: resp[1:0].
  - R: data[8N-1:0] and resp[1:0].
- Constant outputs, all modes:
  - axi4_m burst = 2'b01; len = 0; size = $clog2(N); cache = 0; lock = 0; qos = 0; region = 0; id = 0; wid = 0.
  - axi4_m wlast = 1.
  - axi4_s bid = 0; rid = 0; rlast = 1.
- Channel roles: source = side presenting valid, sink = side presenting ready. Transfer occurs on any edge where valid && ready.
- Mode 0, pass-through:
  - valid, ready and payload are wired straight through; zero latency; no state.
- Mode 1, full:
  - Main register plus one skid register; 1-cycle latency; sustains 1 transfer per cycle under continuous traffic.
  - Upstream ready is registered and equals !skid_valid.
  - Upstream beat when main is empty or draining goes to main; otherwise goes to skid.
  - When main drains and skid is valid, skid moves to main the same cycle.
  - Downstream valid = main_valid; downstream payload = main register.
- Mode 2, light:
  - Single register; upstream ready = !main_valid, combinational from the register only.
  - 1-cycle latency; maximum one transfer per 2 cycles; no combinational path from downstream ready to upstream ready.
- Ordering: strict FIFO per channel; no beat dropped or duplicated; AW and W are independent, no cross-channel ordering imposed.
- AXI stability: once downstream valid is asserted, valid and payload are held unchanged until ready is sampled high.
- Reset (asynchronous assert):
  - All valid outputs driven by registers clear to 0 immediately.
  - Registered ready outputs clear to 0.
  - Payload registers clear to 0.
  - In-flight beats are discarded, including reset mid-handshake.
- Reset release: registered ready rises to 1 on the first clk edge after reset deasserts.
- Simultaneous upstream and downstream transfer in the same cycle:
  - Full mode with skid empty: main loads the new beat.
  - Light mode: impossible, because upstream ready = 0 while main is valid.
- Full-mode boundaries:
  - Downstream stalled for many cycles: exactly 2 beats are accepted, then upstream ready = 0.
  - Downstream ready rising: upstream ready returns to 1 one cycle later.

Test Plan:
- All modes 1, reset then AW addr=0x100 prot=3 with W data=0xDEAD_BEEF_0000_0001 strb=0xFF -> axi4_m awvalid/wvalid high one cycle after acceptance with identical payload; awlen=0, awsize=3, awburst=1, wlast=1.
- AR_MODE=1, stream 16 addresses 0x0..0xF with axi4_m arready held 1 -> 16 AR beats out in order, back-to-back, first one cycle after first acceptance.
- R_MODE=1, axi4_s rready=0 while 3 beats rdata=1,2,3 are offered -> beats 1 and 2 accepted, axi4_m rready=0 on the 3rd; release rready -> 1,2,3 delivered in order, rlast=1, rresp unchanged.
- B_MODE=2, continuous bvalid with bresp=2 and bready=1 -> one transfer every 2 cycles; axi4_m bready never high while the register is valid.
- AW_MODE=0, W_MODE=1 -> awvalid/awready combinational with 0 latency; W 1 cycle; each W beat is delivered exactly once.
- Full mode holding 2 buffered beats, assert reset mid-stall -> axi4_m valids drop immediately; after release ready=1 next edge and no stale beat emerges.
